// File: rtl/ddr4_rank_ca_checker.sv
// DDR4 RDIMM CA-bus checker: per-rank command decode, bank open map, CA parity with alert_n pulse.
// Optional ACT/RD/WR statistics counters are built only when DDR4_CA_CHECK_STATS_EN is defined.
module ddr4_rank_ca_checker #(
  parameter int NUM_RANKS     = 2,
  parameter int MC_ABITS      = 18,
  parameter int MC_BANK_WIDTH = 2,
  parameter int MC_BANK_GROUP = 2,
  parameter int ALERT_PULSE   = 60,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                                   ck_t,
  input  logic                                                   reset,
  input  logic [NUM_RANKS-1:0]                                   cs_n,
  input  logic [NUM_RANKS-1:0]                                   cke,
  input  logic                                                   act_n,
  input  logic [MC_ABITS-1:0]                                    addr,
  input  logic [MC_BANK_WIDTH-1:0]                               ba,
  input  logic [MC_BANK_GROUP-1:0]                               bg,
  input  logic                                                   par,
  output logic                                                   alert_n,
  output logic [NUM_RANKS*(2**(MC_BANK_WIDTH+MC_BANK_GROUP))-1:0] bank_open,
  output logic                                                   proto_err,
  output logic [2:0]                                             proto_err_code,
  output logic [CNT_WIDTH-1:0]                                   par_err_cnt,
  output logic [CNT_WIDTH-1:0]                                   act_cnt,
  output logic [CNT_WIDTH-1:0]                                   rd_cnt,
  output logic [CNT_WIDTH-1:0]                                   wr_cnt
);
  localparam int BW = MC_BANK_WIDTH + MC_BANK_GROUP;
  localparam int NB = 2**BW;

  localparam logic [2:0] FN_MRS = 3'b000;
  localparam logic [2:0] FN_REF = 3'b001;
  localparam logic [2:0] FN_PRE = 3'b010;
  localparam logic [2:0] FN_RFU = 3'b011;
  localparam logic [2:0] FN_WR  = 3'b100;
  localparam logic [2:0] FN_RD  = 3'b101;
  localparam logic [2:0] FN_ZQC = 3'b110;
  localparam logic [2:0] FN_NOP = 3'b111;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ALERT = 1'b1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic [0:0]              r_state;
  logic [7:0]              r_alert_cnt;
  logic [NUM_RANKS*NB-1:0] r_bank_open;
  logic                    r_proto_err;
  logic [2:0]              r_proto_code;
  logic [CNT_WIDTH-1:0]    r_par_cnt;

  logic [NUM_RANKS-1:0]    w_sel;
  logic [3:0]              w_nsel;
  logic                    w_valid, w_multi, w_par_bad, w_busy, w_accept, w_par_hit;
  logic [2:0]              w_fn;
  logic [BW-1:0]           w_bank;
  logic [NB-1:0]           w_onehot, w_clr;
  logic                    w_act, w_rd, w_wr, w_mrs, w_ref, w_pre, w_rfu, w_zqc, w_nop;
  logic                    w_hit_open, w_any_open;
  logic [NUM_RANKS*NB-1:0] w_bank_nxt;
  logic [2:0]              w_code;

  assign w_sel     = ~cs_n & cke;
  assign w_valid   = |w_sel;
  assign w_multi   = (w_nsel > 4'd1);
  assign w_par_bad = ^{act_n, addr, ba, bg, par};
  // The last pulse cycle is not busy: the command sampled as alert_n rises is processed.
  assign w_busy    = (r_state == ST_ALERT) && (r_alert_cnt != 8'd0);
  assign w_par_hit = w_valid && w_par_bad;
  assign w_accept  = w_valid && !w_par_bad && !w_busy;

  assign w_fn     = addr[16:14];
  assign w_bank   = {bg, ba};
  assign w_onehot = NB'(1) << w_bank;
  assign w_clr    = addr[10] ? {NB{1'b1}} : w_onehot;

  assign w_act = ~act_n;
  assign w_mrs = act_n & (w_fn == FN_MRS);
  assign w_ref = act_n & (w_fn == FN_REF);
  assign w_pre = act_n & (w_fn == FN_PRE);
  assign w_rfu = act_n & (w_fn == FN_RFU);
  assign w_wr  = act_n & (w_fn == FN_WR);
  assign w_rd  = act_n & (w_fn == FN_RD);
  assign w_zqc = act_n & (w_fn == FN_ZQC);
  assign w_nop = act_n & (w_fn == FN_NOP);

  // Rank-select population count
  always_comb begin
    w_nsel = 4'd0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      w_nsel = w_nsel + {3'd0, w_sel[r]};
    end
  end

  // Command classification, violation code and next bank map
  always_comb begin
    w_bank_nxt = r_bank_open;
    w_code     = 3'd0;
    w_hit_open = 1'b0;
    w_any_open = 1'b0;
    for (int r = 0; r < NUM_RANKS; r++) begin
      w_hit_open = w_hit_open | (w_sel[r] & (|(r_bank_open[r*NB +: NB] & w_onehot)));
      w_any_open = w_any_open | (w_sel[r] & (|r_bank_open[r*NB +: NB]));
    end
    if (w_accept) begin
      if (w_multi && !(w_mrs || w_ref || w_nop)) begin
        w_code = 3'd1;
      end else if (w_act) begin
        w_code = w_hit_open ? 3'd2 : 3'd0;
        for (int r = 0; r < NUM_RANKS; r++) begin
          w_bank_nxt[r*NB +: NB] = w_bank_nxt[r*NB +: NB] | ({NB{w_sel[r]}} & w_onehot);
        end
      end else if (w_rd || w_wr) begin
        w_code = w_hit_open ? 3'd0 : 3'd3;
      end else if (w_mrs || w_ref || w_zqc) begin
        w_code = w_any_open ? 3'd4 : 3'd0;
      end else if (w_rfu) begin
        w_code = 3'd5;
      end else if (w_pre) begin
        for (int r = 0; r < NUM_RANKS; r++) begin
          w_bank_nxt[r*NB +: NB] = w_bank_nxt[r*NB +: NB] & ~({NB{w_sel[r]}} & w_clr);
        end
      end else begin
        w_code = 3'd0;
      end
    end else begin
      w_code = 3'd0;
    end
  end

  // Alert pulse FSM: parity errors while busy never extend the pulse
  always_ff @(posedge ck_t or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_alert_cnt <= 8'd0;
    end else if (w_busy) begin
      r_alert_cnt <= r_alert_cnt - 8'd1;
    end else if (w_par_hit) begin
      r_state     <= ST_ALERT;
      r_alert_cnt <= 8'(ALERT_PULSE - 1);
    end else begin
      r_state     <= ST_IDLE;
      r_alert_cnt <= 8'd0;
    end
  end

  // Bank map, violation pulse and parity error count
  always_ff @(posedge ck_t or posedge reset) begin
    if (reset) begin
      r_bank_open  <= '0;
      r_proto_err  <= 1'b0;
      r_proto_code <= 3'd0;
      r_par_cnt    <= '0;
    end else begin
      r_bank_open  <= w_bank_nxt;
      r_proto_err  <= (w_code != 3'd0);
      r_proto_code <= w_code;
      r_par_cnt    <= w_par_hit ? sat_inc(r_par_cnt) : r_par_cnt;
    end
  end

`ifdef DDR4_CA_CHECK_STATS_EN
  logic [CNT_WIDTH-1:0] r_act_cnt, r_rd_cnt, r_wr_cnt;

  // Accepted-command statistics; a multi-rank command counts once
  always_ff @(posedge ck_t or posedge reset) begin
    if (reset) begin
      r_act_cnt <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
    end else begin
      r_act_cnt <= (w_accept && w_act) ? sat_inc(r_act_cnt) : r_act_cnt;
      r_rd_cnt  <= (w_accept && w_rd)  ? sat_inc(r_rd_cnt)  : r_rd_cnt;
      r_wr_cnt  <= (w_accept && w_wr)  ? sat_inc(r_wr_cnt)  : r_wr_cnt;
    end
  end

  assign act_cnt = r_act_cnt;
  assign rd_cnt  = r_rd_cnt;
  assign wr_cnt  = r_wr_cnt;
`else
  assign act_cnt = '0;
  assign rd_cnt  = '0;
  assign wr_cnt  = '0;
`endif

  assign alert_n        = (r_state == ST_IDLE);
  assign bank_open      = r_bank_open;
  assign proto_err      = r_proto_err;
  assign proto_err_code = r_proto_code;
  assign par_err_cnt    = r_par_cnt;
endmodule

// File: tb/tb_ddr4_rank_ca_checker.sv
// Randomized and directed bench for ddr4_rank_ca_checker against a per-bank behavioural model.
module tb_ddr4_rank_ca_checker;
  localparam int NR    = 2;
  localparam int NB    = 16;
  localparam int CW    = 4;
  localparam int PULSE = 60;
  localparam int MAXC  = (1 << CW) - 1;

  localparam int K_MRS = 0, K_REF = 1, K_PRE = 2, K_RFU = 3;
  localparam int K_WR  = 4, K_RD  = 5, K_ZQC = 6, K_NOP = 7, K_ACT = 8;

  logic            ck_t = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   cs_n = 2'b11;
  logic [NR-1:0]   cke = 2'b11;
  logic            act_n = 1'b1;
  logic [17:0]     addr = 18'h3c000;
  logic [1:0]      ba = 2'd0;
  logic [1:0]      bg = 2'd0;
  logic            par = 1'b0;
  logic            alert_n;
  logic [NR*NB-1:0] bank_open;
  logic            proto_err;
  logic [2:0]      proto_err_code;
  logic [CW-1:0]   par_err_cnt, act_cnt, rd_cnt, wr_cnt;

  int n_total = 0;
  int n_bad   = 0;

  bit mb [NR][NB];
  int m_alert_left, m_par, m_act, m_rd, m_wr, m_code;
  bit m_err;

  ddr4_rank_ca_checker #(
    .NUM_RANKS(NR), .MC_ABITS(18), .MC_BANK_WIDTH(2), .MC_BANK_GROUP(2),
    .ALERT_PULSE(PULSE), .CNT_WIDTH(CW)
  ) dut (
    .ck_t(ck_t), .reset(reset), .cs_n(cs_n), .cke(cke), .act_n(act_n), .addr(addr),
    .ba(ba), .bg(bg), .par(par), .alert_n(alert_n), .bank_open(bank_open),
    .proto_err(proto_err), .proto_err_code(proto_err_code), .par_err_cnt(par_err_cnt),
    .act_cnt(act_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 ck_t = ~ck_t;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NR*NB-1:0] packed_map();
    logic [NR*NB-1:0] v;
    v = '0;
    for (int r = 0; r < NR; r++)
      for (int b = 0; b < NB; b++)
        v[r*NB + b] = mb[r][b];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++)
      for (int b = 0; b < NB; b++)
        mb[r][b] = 1'b0;
    m_alert_left = 0; m_par = 0; m_act = 0; m_rd = 0; m_wr = 0; m_code = 0; m_err = 1'b0;
  endtask

  // Apply the protocol rules to the command currently on the pins
  task automatic model();
    int nsel, kind, bk;
    bit sel [NR];
    bit busy, hit, anyo;
    nsel = 0;
    for (int r = 0; r < NR; r++) begin
      sel[r] = !cs_n[r] && cke[r];
      nsel += int'(sel[r]);
    end
    busy = m_alert_left > 1;
    if (m_alert_left > 0) m_alert_left--;
    m_err = 1'b0; m_code = 0;
    if (nsel == 0) return;
    if (^{act_n, addr, ba, bg, par}) begin
      if (m_par < MAXC) m_par++;
      if (!busy) m_alert_left = PULSE;
      return;
    end
    if (busy) return;
    bk = int'({bg, ba});
    kind = act_n ? int'(addr[16:14]) : K_ACT;
    hit = 1'b0; anyo = 1'b0;
    for (int r = 0; r < NR; r++) begin
      if (sel[r] && mb[r][bk]) hit = 1'b1;
      for (int b = 0; b < NB; b++)
        if (sel[r] && mb[r][b]) anyo = 1'b1;
    end
    if (kind == K_ACT && m_act < MAXC) m_act++;
    if (kind == K_RD && m_rd < MAXC) m_rd++;
    if (kind == K_WR && m_wr < MAXC) m_wr++;
    if (nsel > 1 && !(kind == K_MRS || kind == K_REF || kind == K_NOP)) m_code = 1;
    else if (kind == K_ACT) begin
      if (hit) m_code = 2;
      for (int r = 0; r < NR; r++) if (sel[r]) mb[r][bk] = 1'b1;
    end else if (kind == K_RD || kind == K_WR) begin
      if (!hit) m_code = 3;
    end else if (kind == K_REF || kind == K_MRS || kind == K_ZQC) begin
      if (anyo) m_code = 4;
    end else if (kind == K_RFU) m_code = 5;
    else if (kind == K_PRE) begin
      for (int r = 0; r < NR; r++)
        if (sel[r]) begin
          if (addr[10]) for (int b = 0; b < NB; b++) mb[r][b] = 1'b0;
          else mb[r][bk] = 1'b0;
        end
    end
    m_err = (m_code != 0);
  endtask

  task automatic compare();
    check_val("alert_n", alert_n, m_alert_left == 0);
    check_val("bank_open", bank_open, packed_map());
    check_val("proto_err", proto_err, m_err);
    if (m_err) check_val("err_code", proto_err_code, m_code);
    check_val("par_err_cnt", par_err_cnt, m_par);
`ifdef DDR4_CA_CHECK_STATS_EN
    check_val("act_cnt", act_cnt, m_act);
    check_val("rd_cnt", rd_cnt, m_rd);
    check_val("wr_cnt", wr_cnt, m_wr);
`else
    check_val("act_cnt", act_cnt, 0);
    check_val("rd_cnt", rd_cnt, 0);
    check_val("wr_cnt", wr_cnt, 0);
`endif
  endtask

  task automatic step();
    @(posedge ck_t);
    model();
    #1;
    compare();
  endtask

  task automatic set_cmd(input logic [1:0] cs, input logic [1:0] ck, input bit a_n,
                         input logic [2:0] fn, input bit a10, input logic [3:0] bank, input bit bad);
    logic [17:0] a;
    a = 18'($urandom);
    a[16:14] = fn;
    a[10] = a10;
    cs_n = cs; cke = ck; act_n = a_n; addr = a; bg = bank[3:2]; ba = bank[1:0];
    par = (^{a_n, a, bank}) ^ bad;
  endtask

  task automatic idle();
    set_cmd(2'b11, 2'b11, 1'b1, 3'b111, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    int low;
    model_reset();
    idle();
    repeat (3) @(posedge ck_t);
    #1;
    check_val("rst_alert_n", alert_n, 1);
    check_val("rst_bank_open", bank_open, 0);
    check_val("rst_proto_err", proto_err, 0);
    check_val("rst_par_cnt", par_err_cnt, 0);
    @(negedge ck_t);
    reset = 1'b0;

    // Open then close rank0 bg=1 ba=2
    set_cmd(2'b10, 2'b11, 1'b0, 3'b000, 1'b0, 4'd6, 1'b0); step();
    check_val("act_bank6", bank_open[6], 1);
    set_cmd(2'b10, 2'b11, 1'b1, 3'b010, 1'b0, 4'd6, 1'b0); step();
    check_val("pre_bank6", bank_open[6], 0);

    // Protocol violations
    set_cmd(2'b10, 2'b11, 1'b0, 3'b000, 1'b0, 4'd5, 1'b0); step();
    set_cmd(2'b10, 2'b11, 1'b0, 3'b000, 1'b0, 4'd5, 1'b0); step();
    check_val("act_open_code", proto_err_code, 2);
    set_cmd(2'b10, 2'b11, 1'b1, 3'b101, 1'b0, 4'd3, 1'b0); step();
    check_val("rd_closed_code", proto_err_code, 3);
    set_cmd(2'b10, 2'b11, 1'b1, 3'b010, 1'b1, 4'd0, 1'b0); step();
    set_cmd(2'b10, 2'b11, 1'b1, 3'b001, 1'b0, 4'd0, 1'b0); step();
    check_val("ref_after_prea", proto_err, 0);
    set_cmd(2'b00, 2'b11, 1'b1, 3'b100, 1'b0, 4'd2, 1'b0); step();
    check_val("multi_wr_code", proto_err_code, 1);
    set_cmd(2'b00, 2'b11, 1'b1, 3'b001, 1'b0, 4'd0, 1'b0); step();
    check_val("multi_ref_ok", proto_err, 0);

    // Parity alert width with a second error mid-pulse
    set_cmd(2'b10, 2'b11, 1'b0, 3'b000, 1'b0, 4'd9, 1'b1); step();
    low = (alert_n == 1'b0) ? 1 : 0;
    for (int i = 1; i < 70; i++) begin
      if (i == 10) set_cmd(2'b01, 2'b11, 1'b0, 3'b000, 1'b0, 4'd1, 1'b1);
      else idle();
      step();
      if (alert_n == 1'b0) low++;
    end
    check_val("alert_width", low, PULSE);
    check_val("par_cnt_two", par_err_cnt, 2);

    // Reset in the middle of a pulse
    set_cmd(2'b10, 2'b11, 1'b0, 3'b000, 1'b0, 4'd4, 1'b1); step();
    idle();
    repeat (19) step();
    #2 reset = 1'b1;
    #1;
    check_val("midrst_alert_n", alert_n, 1);
    check_val("midrst_par_cnt", par_err_cnt, 0);
    check_val("midrst_bank", bank_open, 0);
    model_reset();
    @(negedge ck_t);
    reset = 1'b0;
    set_cmd(2'b01, 2'b11, 1'b0, 3'b000, 1'b0, 4'd7, 1'b0); step();
    check_val("post_rst_act", bank_open[NB + 7], 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int p;
      logic [1:0] cs, ck;
      p  = $urandom_range(0, 9);
      cs = (p == 0) ? 2'b00 : (p == 1) ? 2'b11 : (p < 6) ? 2'b10 : 2'b01;
      ck = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      set_cmd(cs, ck, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
              $urandom_range(0, 5) == 0,
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)),
              $urandom_range(0, 59) == 0);
      step();
    end

    // Parity counter saturation
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      set_cmd(2'b10, 2'b11, 1'b1, 3'b111, 1'b0, 4'd0, 1'b1);
      step();
    end
    check_val("par_cnt_sat", par_err_cnt, 4'hF);
    idle();
    repeat (PULSE + 5) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
